// File: rtl/max_comparator_if.sv
// Bundles the packed input words and the registered arg-max index of max_comparator.
interface max_comparator_if #(
  parameter int DATA_WIDTH        = 16,
  parameter int number_blocks     = 8,
  parameter int BITS_FOR_POSITION = 3
);
  logic [DATA_WIDTH*number_blocks-1:0] values;
  logic [BITS_FOR_POSITION-1:0]        pos_max;

  modport master (output values, input pos_max);
  modport slave  (input values, output pos_max);
endinterface

// File: rtl/max_comparator.sv
// Arg-max of number_blocks signed words via a pairwise comparison tree;
// the winning index is registered once per clk.
module max_comparator #(
  parameter int DATA_WIDTH        = 16,
  parameter int number_blocks     = 8,
  parameter int BITS_FOR_POSITION = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  max_comparator_if.slave   bus
);

  localparam int unsigned LEVELS = $clog2(number_blocks);

  logic signed [DATA_WIDTH-1:0]        cand_val [number_blocks];
  logic        [BITS_FOR_POSITION-1:0] cand_idx [number_blocks];
  logic        [BITS_FOR_POSITION-1:0] pos_max_d;
  logic        [BITS_FOR_POSITION-1:0] pos_max_q;
  int unsigned                         cnt;

  // Tree is folded in place: node i of a level reads slots 2i/2i+1, which are
  // never overwritten before being read, so candidate order (and ties) is kept.
  always_comb begin
    cnt = number_blocks;
    for (int unsigned k = 0; k < number_blocks; k++) begin
      cand_val[k] = bus.values[(number_blocks-k)*DATA_WIDTH-1 -: DATA_WIDTH];
      cand_idx[k] = BITS_FOR_POSITION'(k);
    end
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      for (int unsigned i = 0; i < number_blocks/2; i++) begin
        if (i < cnt/2) begin
          if (cand_val[2*i+1] > cand_val[2*i]) begin
            cand_val[i] = cand_val[2*i+1];
            cand_idx[i] = cand_idx[2*i+1];
          end else begin
            cand_val[i] = cand_val[2*i];
            cand_idx[i] = cand_idx[2*i];
          end
        end
      end
      if ((cnt % 2) == 1) begin
        cand_val[cnt/2] = cand_val[cnt-1];
        cand_idx[cnt/2] = cand_idx[cnt-1];
      end
      cnt = (cnt + 1) / 2;
    end
    pos_max_d = cand_idx[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_max_q <= '0;
    else        pos_max_q <= pos_max_d;
  end

  assign bus.pos_max = pos_max_q;

endmodule

// File: tb/tb_max_comparator.sv
// Directed-vector bench for max_comparator at N=8 and at N=5 (odd pass-through).
module tb_max_comparator;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  max_comparator_if #(.DATA_WIDTH(16), .number_blocks(8), .BITS_FOR_POSITION(3)) bus8 ();
  max_comparator_if #(.DATA_WIDTH(16), .number_blocks(5), .BITS_FOR_POSITION(3)) bus5 ();

  max_comparator #(.DATA_WIDTH(16), .number_blocks(8), .BITS_FOR_POSITION(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  max_comparator #(.DATA_WIDTH(16), .number_blocks(5), .BITS_FOR_POSITION(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.values = '0;
    bus5.values = '0;
    #2;
    checks++;
    if (bus8.pos_max !== 3'd0) begin
      failures++;
      $display("FAIL reset_n8 got=%0d exp=0", bus8.pos_max);
    end
    checks++;
    if (bus5.pos_max !== 3'd0) begin
      failures++;
      $display("FAIL reset_n5 got=%0d exp=0", bus5.pos_max);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ascending();
    bus8.values = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd7) begin
      failures++;
      $display("FAIL ascending got=%0d exp=7", bus8.pos_max);
    end
  endtask

  task automatic test_signed();
    bus8.values = {16'd0, 16'd1, 16'd2, 16'd10, 16'd4, 16'd5, 16'd6, 16'd7};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd3) begin
      failures++;
      $display("FAIL word3_max got=%0d exp=3", bus8.pos_max);
    end
    bus8.values = {16'd0, 16'd1, 16'hFFE7, 16'd10, 16'd4, 16'd5, 16'd6, 16'd7};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd3) begin
      failures++;
      $display("FAIL signed_neg25 got=%0d exp=3", bus8.pos_max);
    end
    bus8.values = {16'd0, 16'd1, 16'hFFE7, 16'd10, 16'd100, 16'd5, 16'd6, 16'd7};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd4) begin
      failures++;
      $display("FAIL word4_max got=%0d exp=4", bus8.pos_max);
    end
    // All negative: -1 at word5 beats every other negative value
    bus8.values = {16'hFFF0, 16'hFF00, 16'h8000, 16'hFFFE, 16'hFFFD, 16'hFFFF, 16'hFFFC, 16'h8001};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd5) begin
      failures++;
      $display("FAIL all_negative got=%0d exp=5", bus8.pos_max);
    end
  endtask

  task automatic test_ties();
    bus8.values = {8{16'd5}};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd0) begin
      failures++;
      $display("FAIL all_equal got=%0d exp=0", bus8.pos_max);
    end
    // Equal maxima at words 2 and 6: lower index wins
    bus8.values = {16'd1, 16'd3, 16'd9, 16'd2, 16'd0, 16'd8, 16'd9, 16'd4};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd2) begin
      failures++;
      $display("FAIL tie_2_6 got=%0d exp=2", bus8.pos_max);
    end
    bus8.values = {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8001, 16'h8000};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd6) begin
      failures++;
      $display("FAIL most_negative got=%0d exp=6", bus8.pos_max);
    end
  endtask

  task automatic test_back_to_back();
    bus8.values = {16'd50, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd0) begin
      failures++;
      $display("FAIL b2b_first got=%0d exp=0", bus8.pos_max);
    end
    // New values are not visible until the next edge
    bus8.values = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd60, 16'd7};
    #3;
    checks++;
    if (bus8.pos_max !== 3'd0) begin
      failures++;
      $display("FAIL b2b_latency got=%0d exp=0", bus8.pos_max);
    end
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd6) begin
      failures++;
      $display("FAIL b2b_second got=%0d exp=6", bus8.pos_max);
    end
    bus8.values = {16'd0, 16'h7FFF, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd1) begin
      failures++;
      $display("FAIL b2b_third got=%0d exp=1", bus8.pos_max);
    end
  endtask

  task automatic test_reset_midstream();
    bus8.values = {16'd0, 16'd1, 16'hFFE7, 16'd10, 16'd100, 16'd5, 16'd6, 16'd7};
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd4) begin
      failures++;
      $display("FAIL pre_reset got=%0d exp=4", bus8.pos_max);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.pos_max !== 3'd0) begin
      failures++;
      $display("FAIL async_reset got=%0d exp=0", bus8.pos_max);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus8.pos_max !== 3'd0) begin
      failures++;
      $display("FAIL post_release got=%0d exp=0", bus8.pos_max);
    end
    @(posedge clk); #1;
    checks++;
    if (bus8.pos_max !== 3'd4) begin
      failures++;
      $display("FAIL after_reset got=%0d exp=4", bus8.pos_max);
    end
  endtask

  task automatic test_n5();
    bus5.values = {16'd1, 16'd2, 16'd3, 16'hFFFF, 16'd20};
    @(posedge clk); #1;
    checks++;
    if (bus5.pos_max !== 3'd4) begin
      failures++;
      $display("FAIL n5_word4 got=%0d exp=4", bus5.pos_max);
    end
    bus5.values = {16'd20, 16'd2, 16'd3, 16'hFFFF, 16'd20};
    @(posedge clk); #1;
    checks++;
    if (bus5.pos_max !== 3'd0) begin
      failures++;
      $display("FAIL n5_tie_0_4 got=%0d exp=0", bus5.pos_max);
    end
    bus5.values = {16'hFFE7, 16'd2, 16'd3, 16'd30, 16'hFFFF};
    @(posedge clk); #1;
    checks++;
    if (bus5.pos_max !== 3'd3) begin
      failures++;
      $display("FAIL n5_word3 got=%0d exp=3", bus5.pos_max);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ascending();
    test_signed();
    test_ties();
    test_back_to_back();
    test_reset_midstream();
    test_n5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
